// File: rtl/l1_msi_controller.sv
// L1 MSI cache controller: 4-line direct-mapped cache of 4-bit data that turns
// processor loads/stores into directory requests and answers directory snoops.
module l1_msi_controller #(
    parameter logic [1:0]  PROC_ID = 2'b01,
    parameter int unsigned LINES   = 4
) (
    input  logic       Clock_i,
    input  logic       Reset_i,
    input  logic       CpuValid_i,
    input  logic       CpuWrite_i,
    input  logic [3:0] CpuAddress_i,
    input  logic [3:0] CpuWdata_i,
    output logic       CpuReady_o,
    output logic [3:0] CpuRdata_o,
    output logic       DirReqValid_o,
    input  logic       DirReqReady_i,
    output logic [2:0] DirReqType_o,
    output logic [3:0] DirReqAddr_o,
    output logic [3:0] DirReqData_o,
    output logic [1:0] DirReqProc_o,
    input  logic       DirRespValid_i,
    input  logic [3:0] DirRespData_i,
    input  logic       SnoopValid_i,
    input  logic [1:0] SnoopType_i,
    input  logic [3:0] SnoopAddr_i,
    output logic       SnoopAck_o,
    output logic       SnoopHit_o,
    output logic [3:0] SnoopData_o
);

    localparam logic [2:0] ST_EMPTY = 3'b000;
    localparam logic [2:0] ST_I     = 3'b001;
    localparam logic [2:0] ST_S     = 3'b010;
    localparam logic [2:0] ST_M     = 3'b011;

    localparam logic [2:0] RQ_READ  = 3'b001;
    localparam logic [2:0] RQ_WRITE = 3'b010;
    localparam logic [2:0] RQ_UPG   = 3'b011;
    localparam logic [2:0] RQ_WB    = 3'b100;

    localparam logic [1:0] SN_INV   = 2'b01;
    localparam logic [1:0] SN_FETCH = 2'b10;
    localparam logic [1:0] SN_FINV  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WB_REQ, MISS_REQ, MISS_WAIT, UPG_REQ, UPG_WAIT
    } state_e;

    state_e     state_q;
    logic [2:0] line_st_q [LINES];
    logic [1:0] tag_q     [LINES];
    logic [3:0] data_q    [LINES];

    logic       req_write_q;
    logic [3:0] req_addr_q;
    logic [3:0] req_wdata_q;

    logic       cpu_ready_q;
    logic [3:0] cpu_rdata_q;
    logic       dir_valid_q;
    logic [2:0] dir_type_q;
    logic [3:0] dir_addr_q;
    logic [3:0] dir_data_q;
    logic [1:0] dir_proc_q;
    logic       snoop_ack_q;
    logic       snoop_hit_q;
    logic [3:0] snoop_data_q;

    logic [1:0] cpu_idx, snp_idx, req_idx;
    logic       cpu_hit, victim_m, snp_hit, snp_kills_req, req_present, upg_lost;

    // Lookup results for the CPU request, the snoop, and the outstanding request
    always_comb begin
        cpu_idx       = CpuAddress_i[1:0];
        snp_idx       = SnoopAddr_i[1:0];
        req_idx       = req_addr_q[1:0];
        cpu_hit       = (line_st_q[cpu_idx] == ST_S || line_st_q[cpu_idx] == ST_M)
                        && tag_q[cpu_idx] == CpuAddress_i[3:2];
        victim_m      = (line_st_q[cpu_idx] == ST_M) && tag_q[cpu_idx] != CpuAddress_i[3:2];
        snp_hit       = (line_st_q[snp_idx] == ST_S || line_st_q[snp_idx] == ST_M)
                        && tag_q[snp_idx] == SnoopAddr_i[3:2];
        snp_kills_req = SnoopValid_i && snp_hit && (SnoopAddr_i == req_addr_q)
                        && (SnoopType_i == SN_INV
                            || (SnoopType_i == SN_FINV && line_st_q[snp_idx] == ST_M));
        req_present   = (line_st_q[req_idx] == ST_S || line_st_q[req_idx] == ST_M)
                        && tag_q[req_idx] == req_addr_q[3:2];
        upg_lost      = !req_present || snp_kills_req;
    end

    // Controller FSM, cache arrays and registered outputs; snoop updates are
    // written before fills so a same-cycle fill to the same line wins
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q      <= IDLE;
            line_st_q    <= '{default: ST_EMPTY};
            tag_q        <= '{default: 2'b00};
            data_q       <= '{default: 4'b0000};
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            dir_valid_q  <= 1'b0;
            dir_type_q   <= '0;
            dir_addr_q   <= '0;
            dir_data_q   <= '0;
            dir_proc_q   <= '0;
            snoop_ack_q  <= 1'b0;
            snoop_hit_q  <= 1'b0;
            snoop_data_q <= '0;
        end else begin
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            snoop_ack_q  <= SnoopValid_i;
            snoop_hit_q  <= SnoopValid_i && snp_hit;
            snoop_data_q <= (SnoopValid_i && snp_hit && line_st_q[snp_idx] == ST_M)
                            ? data_q[snp_idx] : 4'b0000;

            if (SnoopValid_i && snp_hit) begin
                case (SnoopType_i)
                    SN_INV:   line_st_q[snp_idx] <= ST_I;
                    SN_FETCH: if (line_st_q[snp_idx] == ST_M) line_st_q[snp_idx] <= ST_S;
                    SN_FINV:  if (line_st_q[snp_idx] == ST_M) line_st_q[snp_idx] <= ST_I;
                    default:  ;
                endcase
            end

            case (state_q)
                IDLE: begin
                    // A request retiring this cycle is still held by the CPU; skip it
                    if (CpuValid_i && !SnoopValid_i && !cpu_ready_q) begin
                        req_write_q <= CpuWrite_i;
                        req_addr_q  <= CpuAddress_i;
                        req_wdata_q <= CpuWdata_i;
                        if (cpu_hit && !CpuWrite_i) begin
                            cpu_ready_q <= 1'b1;
                            cpu_rdata_q <= data_q[cpu_idx];
                        end else if (cpu_hit && line_st_q[cpu_idx] == ST_M) begin
                            data_q[cpu_idx] <= CpuWdata_i;
                            cpu_ready_q     <= 1'b1;
                        end else begin
                            dir_valid_q <= 1'b1;
                            dir_proc_q  <= PROC_ID;
                            if (cpu_hit) begin
                                dir_type_q <= RQ_UPG;
                                dir_addr_q <= CpuAddress_i;
                                dir_data_q <= '0;
                                state_q    <= UPG_REQ;
                            end else if (victim_m) begin
                                dir_type_q <= RQ_WB;
                                dir_addr_q <= {tag_q[cpu_idx], cpu_idx};
                                dir_data_q <= data_q[cpu_idx];
                                state_q    <= WB_REQ;
                            end else begin
                                dir_type_q <= CpuWrite_i ? RQ_WRITE : RQ_READ;
                                dir_addr_q <= CpuAddress_i;
                                dir_data_q <= '0;
                                state_q    <= MISS_REQ;
                            end
                        end
                    end
                end
                WB_REQ: begin
                    if (DirReqReady_i) begin
                        line_st_q[req_idx] <= ST_I;
                        dir_type_q <= req_write_q ? RQ_WRITE : RQ_READ;
                        dir_addr_q <= req_addr_q;
                        dir_data_q <= '0;
                        state_q    <= MISS_REQ;
                    end
                end
                MISS_REQ, UPG_REQ: begin
                    if (DirReqReady_i) begin
                        dir_valid_q <= 1'b0;
                        dir_type_q  <= '0;
                        dir_addr_q  <= '0;
                        dir_data_q  <= '0;
                        dir_proc_q  <= '0;
                        state_q     <= (state_q == MISS_REQ) ? MISS_WAIT : UPG_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (DirRespValid_i) begin
                        tag_q[req_idx] <= req_addr_q[3:2];
                        cpu_ready_q    <= 1'b1;
                        state_q        <= IDLE;
                        if (req_write_q) begin
                            line_st_q[req_idx] <= ST_M;
                            data_q[req_idx]    <= req_wdata_q;
                        end else begin
                            line_st_q[req_idx] <= ST_S;
                            data_q[req_idx]    <= DirRespData_i;
                            cpu_rdata_q        <= DirRespData_i;
                        end
                    end
                end
                UPG_WAIT: begin
                    // Losing the shared copy turns the upgrade into a full write miss
                    if (upg_lost) begin
                        dir_valid_q <= 1'b1;
                        dir_type_q  <= RQ_WRITE;
                        dir_addr_q  <= req_addr_q;
                        dir_data_q  <= '0;
                        dir_proc_q  <= PROC_ID;
                        state_q     <= MISS_REQ;
                    end else if (DirRespValid_i) begin
                        line_st_q[req_idx] <= ST_M;
                        data_q[req_idx]    <= req_wdata_q;
                        cpu_ready_q        <= 1'b1;
                        state_q            <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CpuReady_o    = cpu_ready_q;
    assign CpuRdata_o    = cpu_rdata_q;
    assign DirReqValid_o = dir_valid_q;
    assign DirReqType_o  = dir_type_q;
    assign DirReqAddr_o  = dir_addr_q;
    assign DirReqData_o  = dir_data_q;
    assign DirReqProc_o  = dir_proc_q;
    assign SnoopAck_o    = snoop_ack_q;
    assign SnoopHit_o    = snoop_hit_q;
    assign SnoopData_o   = snoop_data_q;

endmodule
